arcade_input_conditioner: RTL

//  Sits between keyboard/mist_io joystick sources and the galaxian core's P1/P2_CSJUDLR inputs.

---
 rtl/arcade_input_conditioner_if.sv | 30 +++
 rtl/arcade_input_conditioner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/arcade_input_conditioner_if.sv
// Purpose: bundles the player-control inputs and conditioned core-facing
//          outputs of arcade_input_conditioner.
// Signals:
//   rotate      0 = normal, 1 = rotated joystick control
//   kbjoy       keyboard: [0]fire [1]start1 [2]start2 [3]coin [4]up [5]down [6]left [7]right
//   joystick_0  [0]right [1]left [2]down [3]up [4]fire; [7:5] unused
//   joystick_1  same layout as joystick_0
//   p1_csjudlr  {coin,start1,fire,up,down,left,right} to core P1
//   p2_csjudlr  {1'b0,start2,fire,up,down,left,right} to core P2
//   coin_busy   high whenever the coin sequencer is not idle
// Modports: master = control source side, slave = conditioner.
interface arcade_input_conditioner_if;
  logic       rotate;
  logic [9:0] kbjoy;
  logic [7:0] joystick_0;
  logic [7:0] joystick_1;
  logic [6:0] p1_csjudlr;
  logic [6:0] p2_csjudlr;
  logic       coin_busy;

  modport master (
    output rotate, kbjoy, joystick_0, joystick_1,
    input  p1_csjudlr, p2_csjudlr, coin_busy
  );

  modport slave (
    input  rotate, kbjoy, joystick_0, joystick_1,
    output p1_csjudlr, p2_csjudlr, coin_busy
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Purpose: merges keyboard and joystick controls, synchronizes and debounces
//          them, applies optional cabinet rotation and turns the coin key into
//          a fixed-length one-shot with hold-off for the galaxian core.
// Ports:
//   clk_sys  system clock (sole clock)
//   reset    synchronous, active-high reset
//   bus      arcade_input_conditioner_if.slave (controls in, P1/P2 words out)
module arcade_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 18000,
  parameter int unsigned COIN_PULSE_CYCLES   = 1800000,
  parameter int unsigned COIN_HOLDOFF_CYCLES = 1800000
) (
  input logic                        clk_sys,
  input logic                        reset,
  arcade_input_conditioner_if.slave  bus
);

  localparam int unsigned NB   = 8;
  localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CMAX = (COIN_PULSE_CYCLES > COIN_HOLDOFF_CYCLES) ?
                                 COIN_PULSE_CYCLES : COIN_HOLDOFF_CYCLES;
  localparam int unsigned CCW  = $clog2(CMAX + 1);

  // Logical control indices inside the raw/debounced vectors
  localparam int unsigned B_UP = 0;
  localparam int unsigned B_DN = 1;
  localparam int unsigned B_LT = 2;
  localparam int unsigned B_RT = 3;
  localparam int unsigned B_FR = 4;
  localparam int unsigned B_S1 = 5;
  localparam int unsigned B_S2 = 6;
  localparam int unsigned B_CN = 7;

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF, WAIT_REL} coin_state_t;

  logic [NB-1:0]  raw_c;
  logic [NB-1:0]  sync1;
  logic [NB-1:0]  sync2;
  logic [NB-1:0]  deb;
  logic [DCW-1:0] cnt [NB];

  logic           up_c, down_c, left_c, right_c;
  logic [5:0]     ctl_q;
  logic           start2_q;

  coin_state_t    state;
  logic [CCW-1:0] ccnt;
  logic           coin_q;
  logic           busy_q;
  logic           cd_q;
  logic           coin_rise_c;

  logic           unused_bits;

  // Bits with no function in this block
  assign unused_bits = ^{bus.kbjoy[9:8], bus.joystick_0[7:5], bus.joystick_1[7:5]};

  // Merge every source of a logical control
  always_comb begin
    raw_c       = '0;
    raw_c[B_UP] = bus.kbjoy[4] | bus.joystick_0[3] | bus.joystick_1[3];
    raw_c[B_DN] = bus.kbjoy[5] | bus.joystick_0[2] | bus.joystick_1[2];
    raw_c[B_LT] = bus.kbjoy[6] | bus.joystick_0[1] | bus.joystick_1[1];
    raw_c[B_RT] = bus.kbjoy[7] | bus.joystick_0[0] | bus.joystick_1[0];
    raw_c[B_FR] = bus.kbjoy[0] | bus.joystick_0[4] | bus.joystick_1[4];
    raw_c[B_S1] = bus.kbjoy[1];
    raw_c[B_S2] = bus.kbjoy[2];
    raw_c[B_CN] = bus.kbjoy[3];
  end

  // Two-flop synchronizer and per-bit debounce counters
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          // Stable long enough: accept the new level
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DCW'(1);
        end
      end
    end
  end

  // Cabinet rotation, applied to already-debounced directions
  always_comb begin
    up_c    = bus.rotate ? deb[B_LT] : deb[B_UP];
    down_c  = bus.rotate ? deb[B_RT] : deb[B_DN];
    left_c  = bus.rotate ? deb[B_DN] : deb[B_LT];
    right_c = bus.rotate ? deb[B_UP] : deb[B_RT];
  end

  // Output register for the non-coin player bits
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ctl_q    <= '0;
      start2_q <= 1'b0;
    end else begin
      ctl_q    <= {deb[B_S1], deb[B_FR], up_c, down_c, left_c, right_c};
      start2_q <= deb[B_S2];
    end
  end

  assign coin_rise_c = deb[B_CN] & ~cd_q;

  // Coin one-shot: coin_q and busy_q are updated on the same edge as the
  // state, so the pulse lines up with the other registered player bits.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      ccnt   <= '0;
      coin_q <= 1'b0;
      busy_q <= 1'b0;
      cd_q   <= 1'b0;
    end else begin
      cd_q <= deb[B_CN];
      case (state)
        IDLE: begin
          if (coin_rise_c) begin
            state  <= PULSE;
            ccnt   <= '0;
            coin_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        PULSE: begin
          if (ccnt == CCW'(COIN_PULSE_CYCLES - 1)) begin
            state  <= HOLDOFF;
            ccnt   <= '0;
            coin_q <= 1'b0;
          end else begin
            ccnt <= ccnt + CCW'(1);
          end
        end
        HOLDOFF: begin
          if (ccnt == CCW'(COIN_HOLDOFF_CYCLES - 1)) begin
            ccnt <= '0;
            if (deb[B_CN]) begin
              state <= WAIT_REL;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            ccnt <= ccnt + CCW'(1);
          end
        end
        WAIT_REL: begin
          if (!deb[B_CN]) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ccnt   <= '0;
          coin_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p1_csjudlr = {coin_q, ctl_q};
  assign bus.p2_csjudlr = {1'b0, start2_q, ctl_q[4:0]};
  assign bus.coin_busy  = busy_q;

endmodule
